data_unpack_gearbox: RTL and testbench

- Parametrised successor to the fixed 32-to-7 unpacker.
- Splits IN_W-bit input words into OUT_W-bit output chunks, LSB first, with residue bits carried across words within a packet.
- Adds downstream backpressure (ready_in), zero-padded flush of the partial chunk on end-of-packet, and protocol error reporting.
- Sits between a word-wide packet source and a narrow serialiser/encoder stage.

---
 rtl/data_unpack_gearbox_if.sv | 28 ++
 rtl/data_unpack_gearbox.sv | 118 +++++++++++
 tb/tb_data_unpack_gearbox.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/data_unpack_gearbox_if.sv
// Word-side and chunk-side handshake bundle for data_unpack_gearbox.
// The slave modport is the gearbox's own view; master is the surrounding source/sink view.
interface data_unpack_gearbox_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
);
    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             sop_in;
    logic             eop_in;
    logic             ready_out;
    logic             valid_out;
    logic [OUT_W-1:0] data_out;
    logic             sop_out;
    logic             eop_out;
    logic             ready_in;
    logic             err_out;

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );
endinterface

// File: rtl/data_unpack_gearbox.sv
// Splits IN_W-bit words into OUT_W-bit chunks LSB first, carrying residue within a packet.
// Define UNPACK_LAST_BITS_EN to add the last_bits port (real bits on the eop chunk).
module data_unpack_gearbox #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    data_unpack_gearbox_if.slave       bus
`ifdef UNPACK_LAST_BITS_EN
    ,
    output logic [$clog2(OUT_W+1)-1:0] last_bits
`endif
);
    localparam int BUF_W = IN_W + OUT_W - 1;
    localparam int CNT_W = $clog2(IN_W + OUT_W);
    localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [BUF_W-1:0] bit_buf_q, bit_buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             sop_pend_q, sop_pend_d;
    logic             eop_pend_q, eop_pend_d;
    logic             err_q, err_d;

    logic             ready_w;
    logic             valid_w;
    logic             accept;
    logic             xfer;
    logic [OUT_W-1:0] data_w;

    // Both handshakes are derived from registered state only, so ready_in never reaches ready_out.
    assign ready_w = (state_q == ST_RUN) && (cnt_q < OUT_W_C);
    assign valid_w = (cnt_q >= OUT_W_C) || ((state_q == ST_FLUSH) && (cnt_q != '0));
    assign accept  = bus.valid_in && ready_w;
    assign xfer    = valid_w && bus.ready_in;

    always_comb begin
        data_w = bit_buf_q[OUT_W-1:0];
        if (state_q == ST_FLUSH) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (CNT_W'(i) >= cnt_q) data_w[i] = 1'b0;
            end
        end
    end

    assign bus.ready_out = ready_w;
    assign bus.valid_out = valid_w;
    assign bus.data_out  = data_w;
    assign bus.sop_out   = valid_w && sop_pend_q;
    assign bus.eop_out   = valid_w && eop_pend_q && (cnt_q <= OUT_W_C);
    assign bus.err_out   = err_q;

`ifdef UNPACK_LAST_BITS_EN
    localparam int LB_W = $clog2(OUT_W + 1);
    assign last_bits = !bus.eop_out       ? '0 :
                       (cnt_q < OUT_W_C)  ? LB_W'(cnt_q) : LB_W'(OUT_W);
`endif

    // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        bit_buf_d  = bit_buf_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        sop_pend_d = sop_pend_q;
        eop_pend_d = eop_pend_q;
        err_d      = 1'b0;

        if (accept) begin
            if (bus.sop_in && (cnt_q != '0)) begin
                // A new packet started over stale residue: drop the residue and flag it.
                bit_buf_d = BUF_W'(bus.data_in);
                cnt_d     = IN_W_C;
                err_d     = 1'b1;
            end else begin
                // Bits at and above cnt are always zero, so OR-ing places the word at offset cnt.
                bit_buf_d = bit_buf_q | (BUF_W'(bus.data_in) << cnt_q);
                cnt_d     = cnt_q + IN_W_C;
            end
            if (bus.sop_in) sop_pend_d = 1'b1;
            if (bus.eop_in) begin
                eop_pend_d = 1'b1;
                state_d    = ST_FLUSH;
            end
        end else if (xfer) begin
            bit_buf_d  = bit_buf_q >> OUT_W;
            cnt_d      = (cnt_q >= OUT_W_C) ? (cnt_q - OUT_W_C) : '0;
            sop_pend_d = 1'b0;
            if ((state_q == ST_FLUSH) && (cnt_d == '0)) begin
                state_d    = ST_RUN;
                eop_pend_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_buf_q  <= '0;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            sop_pend_q <= 1'b0;
            eop_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            bit_buf_q  <= bit_buf_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            sop_pend_q <= sop_pend_d;
            eop_pend_q <= eop_pend_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_data_unpack_gearbox.sv
// Directed bench for data_unpack_gearbox with IN_W=32, OUT_W=7: vector table plus
// hand-written reset, exact-fit and reset-mid-flush sequences.
module tb_data_unpack_gearbox;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    data_unpack_gearbox_if #(.IN_W(32), .OUT_W(7)) bus ();

`ifdef UNPACK_LAST_BITS_EN
    logic [2:0] last_bits;
    data_unpack_gearbox #(.IN_W(32), .OUT_W(7)) dut (
        .clk(clk), .rst(rst), .bus(bus), .last_bits(last_bits)
    );
`else
    data_unpack_gearbox #(.IN_W(32), .OUT_W(7)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        s;
        logic        e;
        logic        r;
        logic        xv;
        logic [6:0]  xd;
        logic        xs;
        logic        xe;
        logic        xr;
        logic        xerr;
        logic [2:0]  xlb;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic v, logic [31:0] d, logic s, logic e, logic r,
                                logic xv, logic [6:0] xd, logic xs, logic xe,
                                logic xr, logic xerr, logic [2:0] xlb);
        vec_t t;
        t.v = v; t.d = d; t.s = s; t.e = e; t.r = r;
        t.xv = xv; t.xd = xd; t.xs = xs; t.xe = xe;
        t.xr = xr; t.xerr = xerr; t.xlb = xlb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s,
                         input logic e, input logic r);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.sop_in   = s;
        bus.eop_in   = e;
        bus.ready_in = r;
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].e, vecs[i].r);
            check($sformatf("v%0d_valid", i), 32'(bus.valid_out), 32'(vecs[i].xv));
            check($sformatf("v%0d_ready", i), 32'(bus.ready_out), 32'(vecs[i].xr));
            check($sformatf("v%0d_err", i),   32'(bus.err_out),   32'(vecs[i].xerr));
            if (vecs[i].xv) begin
                check($sformatf("v%0d_data", i), 32'(bus.data_out), 32'(vecs[i].xd));
                check($sformatf("v%0d_sop", i),  32'(bus.sop_out),  32'(vecs[i].xs));
                check($sformatf("v%0d_eop", i),  32'(bus.eop_out),  32'(vecs[i].xe));
            end
`ifdef UNPACK_LAST_BITS_EN
            check($sformatf("v%0d_last_bits", i), 32'(last_bits), 32'(vecs[i].xlb));
`endif
        end
    endtask

    initial begin
        int sent;
        int chunks;

        // Single-word packet with 3 cycles of backpressure on chunk 2; ignored words meanwhile.
        vecs[0]  = mk(1, 32'h12345678, 1, 1, 1,  0, 7'h00, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 32'h0,        0, 0, 1,  1, 7'h78, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 32'hDEADBEEF, 1, 0, 0,  1, 7'h2C, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 32'hDEADBEEF, 1, 0, 0,  1, 7'h2C, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 32'hDEADBEEF, 1, 0, 0,  1, 7'h2C, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 32'h0,        0, 0, 1,  1, 7'h2C, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 32'h0,        0, 0, 1,  1, 7'h51, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 32'h0,        0, 0, 1,  1, 7'h11, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 32'h0,        0, 0, 1,  1, 7'h01, 0, 1, 0, 0, 4);
        vecs[9]  = mk(0, 32'h0,        0, 0, 1,  0, 7'h00, 0, 0, 1, 0, 0);
        // sop-only word leaves 4 residue bits; a second sop word drops them and flags an error.
        vecs[10] = mk(1, 32'hAAAAAAAA, 1, 0, 1,  0, 7'h00, 0, 0, 1, 0, 0);
        vecs[11] = mk(0, 32'h0,        0, 0, 1,  1, 7'h2A, 1, 0, 0, 0, 0);
        vecs[12] = mk(0, 32'h0,        0, 0, 1,  1, 7'h55, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 32'h0,        0, 0, 1,  1, 7'h2A, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 32'h0,        0, 0, 1,  1, 7'h55, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 32'h0000007F, 1, 1, 1,  0, 7'h00, 0, 0, 1, 0, 0);
        vecs[16] = mk(0, 32'h0,        0, 0, 1,  1, 7'h7F, 1, 0, 0, 1, 0);
        vecs[17] = mk(0, 32'h0,        0, 0, 1,  1, 7'h00, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 32'h0,        0, 0, 1,  1, 7'h00, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 32'h0,        0, 0, 1,  1, 7'h00, 0, 0, 0, 0, 0);
        vecs[20] = mk(0, 32'h0,        0, 0, 1,  1, 7'h00, 0, 1, 0, 0, 4);
        vecs[21] = mk(0, 32'h0,        0, 0, 1,  0, 7'h00, 0, 0, 1, 0, 0);

        // Reset held with valid_in high must keep the block idle and ready.
        drive(1, 32'hCAFEF00D, 1, 1, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rst%0d_valid", c), 32'(bus.valid_out), 32'd0);
            check($sformatf("rst%0d_err", c),   32'(bus.err_out),   32'd0);
            check($sformatf("rst%0d_ready", c), 32'(bus.ready_out), 32'd1);
        end
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d_valid", c), 32'(bus.valid_out), 32'd0);
        end

        run_vectors(0, 21);

        // Exact fit: 7 all-ones words make 32 full chunks and no pad chunk.
        sent   = 0;
        chunks = 0;
        for (int c = 0; c < 400 && chunks < 32; c++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                chunks++;
                check($sformatf("fit%0d_data", chunks), 32'(bus.data_out), 32'h7F);
                check($sformatf("fit%0d_sop", chunks),  32'(bus.sop_out),  32'(chunks == 1));
                check($sformatf("fit%0d_eop", chunks),  32'(bus.eop_out),  32'(chunks == 32));
`ifdef UNPACK_LAST_BITS_EN
                if (chunks == 32) check("fit_last_bits", 32'(last_bits), 32'd7);
`endif
            end
            drive(sent < 7, 32'hFFFFFFFF, sent == 0, sent == 6, 1);
            if (bus.valid_in && bus.ready_out) sent++;
        end
        check("fit_words", 32'(sent), 32'd7);
        check("fit_chunks", 32'(chunks), 32'd32);
        @(negedge clk);
        check("fit_no_pad", 32'(bus.valid_out), 32'd0);

        // Reset asserted while chunk 3 of a single-word packet is on the output.
        @(negedge clk);
        drive(1, 32'h12345678, 1, 1, 1);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 1);
        check("mf_chunk1", 32'(bus.data_out), 32'h78);
        @(negedge clk);
        check("mf_chunk2", 32'(bus.data_out), 32'h2C);
        @(negedge clk);
        check("mf_chunk3_valid", 32'(bus.valid_out), 32'd1);
        check("mf_chunk3", 32'(bus.data_out), 32'h51);
        rst = 1'b0;
        #1;
        check("mf_rst_valid", 32'(bus.valid_out), 32'd0);
        check("mf_rst_data",  32'(bus.data_out),  32'd0);
        check("mf_rst_sop",   32'(bus.sop_out),   32'd0);
        check("mf_rst_eop",   32'(bus.eop_out),   32'd0);
        check("mf_rst_ready", 32'(bus.ready_out), 32'd1);
        check("mf_rst_err",   32'(bus.err_out),   32'd0);
        @(negedge clk);
        check("mf_rst_hold", 32'(bus.valid_out), 32'd0);
        rst = 1'b1;

        run_vectors(0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
